// File: rtl/sigmoid_arbiter_pkg.sv
// Shared definitions for the sigmoid arbiter slice.
//   OP_W        : operand width seen by the sigmoid evaluator
//   RES_W       : result width produced by the sigmoid evaluator
//   arb_state_e : arbiter FSM state encodings
package sigmoid_arbiter_pkg;

  localparam int OP_W  = 16;
  localparam int RES_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sigmoid_16bit.sv
// Combinational piecewise-linear sigmoid.
// The operand is signed Q4.12. The result is unsigned Q0.20.
// A result of exactly 1.0 saturates to 20'hFFFFF.
//   x : signed operand
//   y : sigmoid(x)
module sigmoid_16bit
  import sigmoid_arbiter_pkg::*;
(
  input  logic signed [OP_W-1:0]  x,
  output logic        [RES_W-1:0] y
);

  logic [16:0] mag;
  logic [20:0] pos;
  logic [20:0] neg;

  // Evaluate on |x|, then mirror negative inputs using sig(-a) = 1 - sig(a).
  always_comb begin
    mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
    if (mag >= 17'd20480) begin
      pos = 21'd1048576;                          // |x| >= 5.0 -> 1.0
    end else if (mag >= 17'd9728) begin
      pos = (21'(mag) << 3) + 21'd884736;         // a/32 + 0.84375
    end else if (mag >= 17'd4096) begin
      pos = (21'(mag) << 5) + 21'd655360;         // a/8 + 0.625
    end else begin
      pos = (21'(mag) << 6) + 21'd524288;         // a/4 + 0.5
    end
    neg = 21'd1048576 - pos;
    if (x[15]) begin
      y = neg[19:0];
    end else if (pos[20]) begin
      y = 20'hFFFFF;
    end else begin
      y = pos[19:0];
    end
  end

endmodule

// File: rtl/sigmoid_arbiter_rr_pick.sv
// Round-robin picker.
// Selects the first set request bit at or above ptr, wrapping modulo NREQ.
//   req_valid : request vector
//   ptr       : highest-priority index
//   gnt_idx   : chosen index (valid only when gnt_any is 1)
//   gnt_any   : at least one request is set
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 2
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [TAG_W-1:0] ptr,
  output logic [TAG_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  // Scan from the farthest offset down to 0, so the nearest hit to ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx     = (int'(ptr) + k) % NREQ;
      gnt_idx = req_valid[idx] ? TAG_W'(idx) : gnt_idx;
      gnt_any = gnt_any | req_valid[idx];
    end
  end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Shares one sigmoid_16bit evaluator among NREQ requesters.
// Only one request is in flight at a time. The arbiter registers the operand
// and the result, and returns each result on a tagged valid/ready channel.
//   clk, rst   : clock; synchronous active-high reset
//   req_valid  : per-requester operand present
//   req_data   : packed 16-bit signed operands, operand i at [16*i +: 16]
//   req_ready  : one-hot accept, asserted only in IDLE
//   out_valid  : result available
//   out_ready  : consumer accepts the result
//   out_data   : 20-bit sigmoid result
//   out_tag    : index of the requester that owns out_data
module sigmoid_arbiter
  import sigmoid_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*OP_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RES_W-1:0]     out_data,
  output logic [TAG_W-1:0]     out_tag
);

  arb_state_e       state;
  arb_state_e       state_nx;
  logic [TAG_W-1:0] ptr;
  logic [OP_W-1:0]  x_q;
  logic [TAG_W-1:0] tag_q;
  logic [RES_W-1:0] out_q;
  logic [TAG_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [RES_W-1:0] sig_y;
  logic [OP_W-1:0]  ops [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign ops[i] = req_data[i*OP_W +: OP_W];
  end

  rr_pick #(.NREQ(NREQ), .TAG_W(TAG_W)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  sigmoid_16bit u_sig (
    .x (x_q),
    .y (sig_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nx = EVAL;
        end else begin
          state_nx = IDLE;
        end
        // A reset that coincides with a grant cancels the handshake.
        if (gnt_any && !rst) begin
          req_ready = NREQ'(1) << gnt_idx;
        end else begin
          req_ready = '0;
        end
      end
      EVAL:    state_nx = RESP;
      RESP: begin
        if (out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = RESP;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand, tag, result and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      x_q   <= '0;
      tag_q <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            x_q   <= ops[gnt_idx];
            tag_q <= gnt_idx;
          end
        end
        EVAL: out_q <= sig_y;
        RESP: begin
          // Wrap explicitly because NREQ need not be a power of two.
          if (out_ready) begin
            ptr <= (tag_q == TAG_W'(NREQ - 1)) ? '0 : tag_q + TAG_W'(1);
          end
        end
        default: ptr <= '0;
      endcase
    end
  end

  assign out_valid = (state == RESP);
  assign out_data  = out_q;
  assign out_tag   = tag_q;

endmodule
